// File: rtl/v_pkg.sv
// v_pkg
// Shared types for the list query path: product id, level, the state-table
// entry layout and the state-table address built from {prod_id, level}.
// No ports; imported by the query pipe, its interface and the bench.
package v_pkg;

  localparam int ID_W       = 8;
  // One bit wider than the 16 legal levels need, so an out-of-range level
  // can be presented and rejected.
  localparam int LEVEL_W    = 5;
  localparam int KEY_W      = 8;
  localparam int SIZE_W     = 8;
  localparam int LISTSIZE_W = 8;
  localparam int ADDR_W     = ID_W + LEVEL_W;

  typedef logic [ID_W-1:0]       id_t;
  typedef logic [LEVEL_W-1:0]    level_t;
  typedef logic [KEY_W-1:0]      key_t;
  typedef logic [SIZE_W-1:0]     size_t;
  typedef logic [LISTSIZE_W-1:0] listsize_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef struct packed {
    logic      vld;
    key_t      key;
    size_t     size;
    listsize_t listsize;
  } state_t;

  function automatic addr_t state_addr(input id_t id, input level_t level);
    return {id, level};
  endfunction

endpackage

// File: rtl/v_pipe_query_mc_if.sv
// v_pipe_query_mc_if
// Bundles the per-channel lookup request/response signals and the
// state-table read port of v_pipe_query_mc.
//   slave  : the query pipe (consumes requests and read data).
//   master : the clients plus state storage (drive requests and read data).
//
// Handshake: a request on channel c transfers in the cycle where
// i_lut_vld[c] & o_lut_rdy[c]; the requester holds id/level stable until
// then. Responses have no ready: o_lut_rsp_vld pulses once per response and
// must be taken that cycle. i_state_rdata is valid the cycle after
// o_state_ren.
interface v_pipe_query_mc_if #(
  parameter int N_CH      = 2,
  parameter int ERR_CNT_W = 8
);
  import v_pkg::*;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]                 i_lut_vld;
  id_t  [N_CH-1:0]                 i_lut_prod_id;
  level_t [N_CH-1:0]               i_lut_level;
  logic [N_CH-1:0]                 o_lut_rdy;
  logic                            o_lut_rsp_vld;
  logic [CH_W-1:0]                 o_lut_rsp_ch;
  key_t                            o_lut_key;
  size_t                           o_lut_size;
  listsize_t                       o_lut_listsize;
  logic                            o_lut_error;
  logic [N_CH-1:0][ERR_CNT_W-1:0]  o_lut_err_cnt;
  state_t                          i_state_rdata;
  logic                            o_state_ren;
  addr_t                           o_state_raddr;

  modport slave (
    input  i_lut_vld, i_lut_prod_id, i_lut_level, i_state_rdata,
    output o_lut_rdy, o_lut_rsp_vld, o_lut_rsp_ch, o_lut_key, o_lut_size,
           o_lut_listsize, o_lut_error, o_lut_err_cnt, o_state_ren,
           o_state_raddr
  );

  modport master (
    output i_lut_vld, i_lut_prod_id, i_lut_level, i_state_rdata,
    input  o_lut_rdy, o_lut_rsp_vld, o_lut_rsp_ch, o_lut_key, o_lut_size,
           o_lut_listsize, o_lut_error, o_lut_err_cnt, o_state_ren,
           o_state_raddr
  );

endinterface

// File: rtl/v_rr_arb.sv
// v_rr_arb
// Round-robin arbiter. Priority starts at ptr and wraps modulo N; the grant
// is combinational from req and ptr. After a grant to channel c with adv
// high, ptr moves to (c+1) mod N; otherwise it holds.
// Ports:
//   clk, rst : clock, synchronous active-high reset (ptr -> 0)
//   req      : request vector
//   adv      : allow ptr to advance on a grant
//   gnt      : one-hot grant (zero when no request)
//   idx      : index of the granted channel (0 when no grant)
module v_rr_arb #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;
  int            sum;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    sum   = 0;
    for (int i = 0; i < N; i++) begin
      // Wrap explicitly so non-power-of-two N never indexes past N-1.
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/v_pipe_query_mc.sv
// v_pipe_query_mc
// Multi-channel list query pipe. Requests from N_CH channels are arbitrated
// round-robin onto one state-table read port; each accepted request yields
// one tagged response exactly two cycles later, in acceptance order.
//   S0 (grant cycle) : range check, read enable/address driven combinationally.
//   S1               : {vld, ch, oor} registered while the read is in flight.
//   Output           : read data sampled, error applied, response presented.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   lut      : v_pipe_query_mc_if.slave (requests, responses, error counts,
//              state read port)
module v_pipe_query_mc #(
  parameter int N_CH      = 2,
  parameter int LEVELS_N  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  v_pipe_query_mc_if.slave      lut
);
  import v_pkg::*;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // ---------------- S0: arbitration and issue ----------------
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            adv;
  id_t             sel_id;
  level_t          sel_level;
  logic            s0_oor;

  // Masking requests during reset keeps rdy and ren low while rst is high.
  assign req = rst ? '0 : lut.i_lut_vld;
  assign adv = ~rst;

  v_rr_arb #(.N(N_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (adv),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign sel_id    = lut.i_lut_prod_id[gnt_idx];
  assign sel_level = lut.i_lut_level[gnt_idx];
  assign s0_oor    = int'(sel_level) >= LEVELS_N;

  assign lut.o_lut_rdy     = gnt;
  // Out-of-range requests never touch the table but still occupy a slot.
  assign lut.o_state_ren   = gnt_any & ~s0_oor;
  assign lut.o_state_raddr = state_addr(sel_id, sel_level);

  // ---------------- S1: tag while the read is in flight ----------------
  logic            s1_vld;
  logic [CH_W-1:0] s1_ch;
  logic            s1_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_ch  <= '0;
      s1_oor <= 1'b0;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        s1_ch  <= gnt_idx;
        s1_oor <= s0_oor;
      end
    end
  end

  // ---------------- Output stage ----------------
  logic            s1_err;
  logic            rsp_vld;
  logic [CH_W-1:0] rsp_ch;
  key_t            rsp_key;
  size_t           rsp_size;
  listsize_t       rsp_listsize;
  logic            rsp_error;

  // rdata is meaningless for an out-of-range entry, so oor masks it.
  assign s1_err = s1_oor | ~lut.i_state_rdata.vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld      <= 1'b0;
      rsp_ch       <= '0;
      rsp_key      <= '0;
      rsp_size     <= '0;
      rsp_listsize <= '0;
      rsp_error    <= 1'b0;
    end else begin
      rsp_vld <= s1_vld;
      // Data fields hold their last value between responses.
      if (s1_vld) begin
        rsp_ch    <= s1_ch;
        rsp_error <= s1_err;
        if (s1_err) begin
          rsp_key      <= '0;
          rsp_size     <= '0;
          rsp_listsize <= '0;
        end else begin
          rsp_key      <= lut.i_state_rdata.key;
          rsp_size     <= lut.i_state_rdata.size;
          rsp_listsize <= lut.i_state_rdata.listsize;
        end
      end
    end
  end

  assign lut.o_lut_rsp_vld  = rsp_vld;
  assign lut.o_lut_rsp_ch   = rsp_ch;
  assign lut.o_lut_key      = rsp_key;
  assign lut.o_lut_size     = rsp_size;
  assign lut.o_lut_listsize = rsp_listsize;
  assign lut.o_lut_error    = rsp_error;

  // ---------------- Per-channel saturating error counters ----------------
  // Counted from the registered response, so a count moves the cycle after
  // the error response is presented.
  logic [N_CH-1:0][ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (rsp_vld && rsp_error && (rsp_ch == CH_W'(c)) && !(&err_cnt[c])) begin
          err_cnt[c] <= err_cnt[c] + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign lut.o_lut_err_cnt = err_cnt;

endmodule

// File: tb/tb_v_pipe_query_mc.sv
// Bench for v_pipe_query_mc (N_CH=2, LEVELS_N=16, ERR_CNT_W=8).
// Directed vectors; expected responses go into exp_q when a grant is
// expected, a monitor pops and compares on every o_lut_rsp_vld.
module tb_v_pipe_query_mc;
  import v_pkg::*;

  localparam int N_CH      = 2;
  localparam int LEVELS_N  = 16;
  localparam int ERR_CNT_W = 8;
  localparam int W         = 2 + KEY_W + SIZE_W + LISTSIZE_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  v_pipe_query_mc_if #(.N_CH(N_CH), .ERR_CNT_W(ERR_CNT_W)) lut_if ();

  v_pipe_query_mc #(
    .N_CH      (N_CH),
    .LEVELS_N  (LEVELS_N),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lut (lut_if)
  );

  // ---------------- state storage model ----------------
  state_t mem [0:(1 << ADDR_W) - 1];

  always @(posedge clk) begin
    if (lut_if.o_state_ren) lut_if.i_state_rdata <= mem[lut_if.o_state_raddr];
  end

  function automatic addr_t a_of(input id_t i, input level_t l);
    return {i, l};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_cnt [N_CH];
  int           n_chk  = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] pack_rsp(input logic ch, input state_t e, input logic oor);
    if (oor || !e.vld) return {ch, 1'b1, 24'h0};
    return {ch, 1'b0, e.key, e.size, e.listsize};
  endfunction

  logic [W-1:0] got_rsp;
  logic [W-1:0] exp_rsp;
  int           exp_at;

  always @(negedge clk) begin
    if (lut_if.o_lut_rsp_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        got_rsp = {lut_if.o_lut_rsp_ch, lut_if.o_lut_error, lut_if.o_lut_key,
                   lut_if.o_lut_size, lut_if.o_lut_listsize};
        exp_rsp = exp_q.pop_front();
        exp_at  = exp_cyc_q.pop_front();
        check("rsp_data", 32'(got_rsp), 32'(exp_rsp));
        check("rsp_cycle", cyc, exp_at);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One request cycle: drive both channels, check the expected grant and
  // read port, and queue the response when a grant is expected.
  task automatic req_cycle(input logic [1:0] v, input id_t id0, input level_t l0,
                           input id_t id1, input level_t l1, input int exp_ch,
                           input bit push);
    id_t        id;
    level_t     lv;
    logic       oor;
    addr_t      a;
    logic [1:0] exp_rdy;
    @(negedge clk);
    lut_if.i_lut_vld        = v;
    lut_if.i_lut_prod_id[0] = id0;
    lut_if.i_lut_level[0]   = l0;
    lut_if.i_lut_prod_id[1] = id1;
    lut_if.i_lut_level[1]   = l1;
    #1;
    exp_rdy = (exp_ch < 0) ? 2'b00 : (2'b01 << exp_ch);
    check("rdy", 32'(lut_if.o_lut_rdy), 32'(exp_rdy));
    if (exp_ch >= 0) begin
      id  = (exp_ch == 0) ? id0 : id1;
      lv  = (exp_ch == 0) ? l0 : l1;
      oor = int'(lv) >= LEVELS_N;
      a   = a_of(id, lv);
      check("ren", 32'(lut_if.o_state_ren), 32'(!oor));
      if (!oor) check("raddr", 32'(lut_if.o_state_raddr), 32'(a));
      if (push) begin
        exp_q.push_back(pack_rsp(exp_ch[0], mem[a], oor));
        exp_cyc_q.push_back(cyc + 2);
        if ((oor || !mem[a].vld) && exp_cnt[exp_ch] < 255) exp_cnt[exp_ch]++;
      end
    end else begin
      check("ren_idle", 32'(lut_if.o_state_ren), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lut_if.i_lut_vld = 2'b00;
    end
  endtask

  // Both channels hold requests until served; with ptr at 0 the grants
  // alternate 0,1,0,1 while both still have work.
  task automatic contend(input int n0, input int n1);
    int g0;
    int g1;
    int ec;
    g0 = 0;
    g1 = 0;
    while (g0 < n0 || g1 < n1) begin
      if (g0 < n0 && g1 < n1) ec = (g0 + g1) % 2;
      else ec = (g0 < n0) ? 0 : 1;
      req_cycle({g1 < n1, g0 < n0}, id_t'(8'h10 + g0), 5'd1,
                id_t'(8'h20 + g1), 5'd3, ec, 1'b1);
      if (ec == 0) g0++;
      else g1++;
    end
  endtask

  task automatic check_cnt(input string name);
    check({name, "_cnt0"}, 32'(lut_if.o_lut_err_cnt[0]), 32'(exp_cnt[0]));
    check({name, "_cnt1"}, 32'(lut_if.o_lut_err_cnt[1]), 32'(exp_cnt[1]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[a_of(8'h03, 5'd2)] = '{vld: 1'b1, key: 8'hAB, size: 8'h04, listsize: 8'h07};
    for (int k = 0; k < 4; k++) begin
      mem[a_of(id_t'(8'h10 + k), 5'd1)] =
        '{vld: 1'b1, key: key_t'(8'h40 + k), size: size_t'(8'h01 + k), listsize: listsize_t'(8'h09 + k)};
      mem[a_of(id_t'(8'h20 + k), 5'd3)] =
        '{vld: (k != 2), key: key_t'(8'h60 + k), size: size_t'(8'h11 + k), listsize: listsize_t'(8'h21 + k)};
    end
    mem[a_of(8'h30, 5'd0)]  = '{vld: 1'b0, key: 8'hEE, size: 8'h05, listsize: 8'h06};
    mem[a_of(8'h31, 5'd15)] = '{vld: 1'b1, key: 8'h5C, size: 8'h02, listsize: 8'h03};
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    lut_if.i_lut_vld     = 2'b00;
    lut_if.i_lut_prod_id = '0;
    lut_if.i_lut_level   = '0;

    // Reset state, with both channels requesting.
    repeat (3) @(negedge clk);
    lut_if.i_lut_vld = 2'b11;
    #1;
    check("rst_rdy", 32'(lut_if.o_lut_rdy), 32'd0);
    check("rst_ren", 32'(lut_if.o_state_ren), 32'd0);
    check("rst_rsp_vld", 32'(lut_if.o_lut_rsp_vld), 32'd0);
    check("rst_rsp_ch", 32'(lut_if.o_lut_rsp_ch), 32'd0);
    check("rst_data", {8'h0, lut_if.o_lut_key, lut_if.o_lut_size, lut_if.o_lut_listsize}, 32'd0);
    check("rst_error", 32'(lut_if.o_lut_error), 32'd0);
    check_cnt("rst");
    @(negedge clk);
    rst = 1'b0;
    lut_if.i_lut_vld = 2'b00;

    // Contention: 4 each, alternating from ch0, back-to-back responses.
    contend(4, 4);
    idle(3);
    check_cnt("contend");

    // Single request on ch0, then the response fields hold when idle.
    req_cycle(2'b01, 8'h03, 5'd2, 8'h00, 5'd0, 0, 1'b1);
    idle(3);
    #1;
    check("hold_vld", 32'(lut_if.o_lut_rsp_vld), 32'd0);
    check("hold_key", 32'(lut_if.o_lut_key), 32'hAB);

    // Out of range (level 16) and the top legal level on ch1.
    req_cycle(2'b10, 8'h00, 5'd0, 8'h31, 5'd16, 1, 1'b1);
    idle(3);
    check_cnt("oor");
    req_cycle(2'b10, 8'h00, 5'd0, 8'h31, 5'd15, 1, 1'b1);

    // Invalid entry on ch0 (leaves ptr at 1).
    req_cycle(2'b01, 8'h30, 5'd0, 8'h00, 5'd0, 0, 1'b1);
    // ptr=1: ch1 wins, then the held ch0 out-of-range request.
    req_cycle(2'b11, 8'h03, 5'd20, 8'h31, 5'd15, 1, 1'b1);
    req_cycle(2'b01, 8'h03, 5'd20, 8'h31, 5'd15, 0, 1'b1);
    idle(3);
    check_cnt("mixed");

    // Saturation on ch0.
    for (int i = 0; i < 257; i++) req_cycle(2'b01, 8'h44, 5'd31, 8'h00, 5'd0, 0, 1'b1);
    idle(3);
    check_cnt("sat");

    // Reset mid-flight: accept on ch0 (ptr -> 1), then one reset cycle.
    req_cycle(2'b01, 8'h03, 5'd2, 8'h00, 5'd0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    lut_if.i_lut_vld = 2'b11;
    #1;
    check("midrst_rdy", 32'(lut_if.o_lut_rdy), 32'd0);
    check("midrst_ren", 32'(lut_if.o_state_ren), 32'd0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    lut_if.i_lut_vld = 2'b00;
    #1;
    check("midrst_t2", 32'(lut_if.o_lut_rsp_vld), 32'd0);
    @(negedge clk);
    #1;
    check("midrst_t3", 32'(lut_if.o_lut_rsp_vld), 32'd0);
    check_cnt("midrst");
    contend(1, 1);
    idle(4);
    check_cnt("final");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
